// File: rtl/input_wrapper.sv
// Four-word input buffer: captures words from a four-phase request/acknowledge
// sender, then hands the full batch to the core with a one-cycle start pulse.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | batch boundary, slot counter cleared
// WAIT_DATA | waiting for sender request
// LOAD      | capture data_in into slot word_cnt
// ACK       | got_data high until sender drops its request
// WAIT_CORE | all four slots full, waiting for ready_for_input
// START     | one-cycle start pulse, batch valid on data_out
module input_wrapper #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 data_ready,
    input  logic                 ready_for_input,
    output logic                 got_data,
    output logic                 start,
    output logic                 buffer_full,
    output logic [1:0]           word_cnt,
    output logic [4*WIDTH-1:0]   data_out
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DATA = 3'd1,
        LOAD      = 3'd2,
        ACK       = 3'd3,
        WAIT_CORE = 3'd4,
        START     = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] buf_q [4];
    logic             load_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d   = 2'd0;
                state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (data_ready)
                    state_d = LOAD;
            end
            LOAD: begin
                state_d = ACK;
            end
            ACK: begin
                // Counter advances only once the sender releases its request,
                // so a long request still captures a single word.
                if (!data_ready) begin
                    cnt_d   = cnt_q + 2'd1;
                    state_d = (cnt_q == 2'd3) ? WAIT_CORE : WAIT_DATA;
                end
            end
            WAIT_CORE: begin
                if (ready_for_input)
                    state_d = START;
            end
            START: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        got_data    = (state_q == ACK);
        start       = (state_q == START);
        buffer_full = (state_q == WAIT_CORE);
        load_en     = (state_q == LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++)
                buf_q[i] <= '0;
        end else if (load_en) begin
            buf_q[cnt_q] <= data_in;
        end
    end

    assign word_cnt = cnt_q;

    for (genvar g = 0; g < 4; g++) begin : g_out
        assign data_out[g*WIDTH +: WIDTH] = buf_q[g];
    end

endmodule

// File: tb/tb_input_wrapper.sv
// Directed bench for input_wrapper: reset during a handshake, nominal batch,
// long request, back-pressure and back-to-back batches.
module tb_input_wrapper;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic        data_ready;
    logic        ready_for_input;
    logic        got_data;
    logic        start;
    logic        buffer_full;
    logic [1:0]  word_cnt;
    logic [63:0] data_out;

    int passes = 0;
    int total  = 0;

    input_wrapper #(.WIDTH(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_in         (data_in),
        .data_ready      (data_ready),
        .ready_for_input (ready_for_input),
        .got_data        (got_data),
        .start           (start),
        .buffer_full     (buffer_full),
        .word_cnt        (word_cnt),
        .data_out        (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called with the FSM in WAIT_DATA at a falling edge; returns at the
    // falling edge after the sender has dropped its request.
    task automatic send(input logic [15:0] w, input logic [1:0] idx, input int hold);
        data_in    = w;
        data_ready = 1'b1;
        @(negedge clk);
        check("ack_early", {63'd0, got_data}, 64'd0);
        @(negedge clk);
        check("ack", {63'd0, got_data}, 64'd1);
        check("cnt_ack", {62'd0, word_cnt}, {62'd0, idx});
        check("no_start", {63'd0, start}, 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("ack_hold", {63'd0, got_data}, 64'd1);
            check("cnt_hold", {62'd0, word_cnt}, {62'd0, idx});
        end
        data_ready = 1'b0;
        data_in    = 16'hDEAD;
        @(negedge clk);
        check("ack_drop", {63'd0, got_data}, 64'd0);
        check("cnt_next", {62'd0, word_cnt}, {62'd0, idx + 2'd1});
    endtask

    // Called in WAIT_CORE with ready_for_input already high.
    task automatic end_batch(input logic [63:0] exp);
        check("full", {63'd0, buffer_full}, 64'd1);
        check("start_pre", {63'd0, start}, 64'd0);
        @(negedge clk);
        check("start", {63'd0, start}, 64'd1);
        check("full_clr", {63'd0, buffer_full}, 64'd0);
        check("batch", data_out, exp);
        check("cnt_start", {62'd0, word_cnt}, 64'd0);
        @(negedge clk);
        check("start_once", {63'd0, start}, 64'd0);
        @(negedge clk);
        check("batch_held", data_out, exp);
        check("idle_ack", {63'd0, got_data}, 64'd0);
    endtask

    initial begin
        rst             = 1'b1;
        data_in         = 16'h0000;
        data_ready      = 1'b0;
        ready_for_input = 1'b0;
        #1;
        check("rst_out", data_out, 64'd0);
        check("rst_flags", {61'd0, got_data, start, buffer_full}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of the second handshake
        send(16'h1234, 2'd0, 0);
        check("slot0", data_out, 64'h0000_0000_0000_1234);
        data_in    = 16'h5678;
        data_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mid_ack", {63'd0, got_data}, 64'd1);
        check("mid_cnt", {62'd0, word_cnt}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_ack", {63'd0, got_data}, 64'd0);
        check("async_cnt", {62'd0, word_cnt}, 64'd0);
        check("async_out", data_out, 64'd0);
        @(negedge clk);
        rst        = 1'b0;
        data_ready = 1'b0;
        @(negedge clk);

        // Nominal batch, core ready throughout
        ready_for_input = 1'b1;
        send(16'h1111, 2'd0, 0);
        send(16'h2222, 2'd1, 0);
        send(16'h3333, 2'd2, 0);
        send(16'h4444, 2'd3, 0);
        end_batch(64'h4444_3333_2222_1111);

        // Long request on slot 0, then back-pressure
        ready_for_input = 1'b0;
        send(16'hAAAA, 2'd0, 10);
        check("one_slot", data_out, 64'h4444_3333_2222_AAAA);
        send(16'hBBBB, 2'd1, 0);
        send(16'hCCCC, 2'd2, 0);
        send(16'hDDDD, 2'd3, 0);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                data_in    = 16'hEEEE;
                data_ready = 1'b1;
            end
            check("bp_full", {63'd0, buffer_full}, 64'd1);
            check("bp_ack", {63'd0, got_data}, 64'd0);
            check("bp_start", {63'd0, start}, 64'd0);
            @(negedge clk);
        end
        data_ready      = 1'b0;
        ready_for_input = 1'b1;
        end_batch(64'hDDDD_CCCC_BBBB_AAAA);

        // Back-to-back batches
        send(16'h0001, 2'd0, 0);
        send(16'h0002, 2'd1, 0);
        send(16'h0003, 2'd2, 0);
        send(16'h0004, 2'd3, 0);
        end_batch(64'h0004_0003_0002_0001);
        send(16'h0005, 2'd0, 0);
        check("b2b_partial", data_out, 64'h0004_0003_0002_0005);
        send(16'h0006, 2'd1, 0);
        send(16'h0007, 2'd2, 0);
        send(16'h0008, 2'd3, 0);
        end_batch(64'h0008_0007_0006_0005);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/input_wrapper.md
INPUT_WRAPPER -- requirements
Module: input_wrapper

Interface
REQ-001 Parameter: WIDTH, default 16, bit width of one data word.
REQ-002 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: data_in  input  WIDTH  word from upstream sender; stable while data_ready=1.
REQ-005 Port: data_ready  input  1  upstream sender's request; high means data_in is valid.
REQ-006 Port: ready_for_input  input  1  downstream core/output stage can accept a new batch.
REQ-007 Port: got_data  output  1  acknowledge to sender; word has been captured.
REQ-008 Port: start  output  1  one-cycle pulse to core; batch in data_out is valid.
REQ-009 Port: buffer_full  output  1  all 4 words captured; waiting for ready_for_input.
REQ-010 Port: word_cnt  output  2  index of the next buffer slot to fill.
REQ-011 Port: data_out  output  4*WIDTH  buffer contents; slot i at bits [i*WIDTH +: WIDTH].

Function
REQ-012 The block SHALL be a 4-entry word buffer with a 2-bit slot counter and a Moore FSM controller.
REQ-013 The FSM SHALL have states IDLE, WAIT_DATA, LOAD, ACK, WAIT_CORE and START.
REQ-014 IDLE: clear word_cnt to 0; go to WAIT_DATA on the next clock edge.
REQ-015 WAIT_DATA: if data_ready=1, go to LOAD; otherwise stay.
REQ-016 LOAD: write data_in into slot word_cnt on the exiting edge; go to ACK unconditionally.
REQ-017 ACK: drive got_data=1; stay while data_ready=1.
REQ-018 ACK with data_ready=0 and word_cnt<3: increment word_cnt; go to WAIT_DATA.
REQ-019 ACK with data_ready=0 and word_cnt=3 (carry-out): wrap word_cnt to 0; go to WAIT_CORE.
REQ-020 WAIT_CORE: drive buffer_full=1; if ready_for_input=1, go to START; otherwise stay.
REQ-021 START: drive start=1 for exactly one cycle; go to IDLE.
REQ-022 got_data, start and buffer_full SHALL be decoded from the state only, never directly from inputs.
REQ-023 Each word SHALL be captured exactly once per four-phase handshake, even if data_ready stays high for many cycles.
REQ-024 data_out SHALL hold its contents unchanged from the START state until each slot is overwritten in the next batch.
REQ-025 Latency: data_ready sampled high in WAIT_DATA at edge E -> word written and got_data=1 after edge E+1.
REQ-026 Latency: data_ready low in ACK at edge E -> got_data=0 after E.
REQ-027 Latency: ready_for_input sampled high in WAIT_CORE at edge E -> start=1 for the cycle after E.
REQ-028 ready_for_input SHALL be ignored in every state except WAIT_CORE.
REQ-029 data_ready SHALL be ignored in WAIT_CORE, START and IDLE; the sender is stalled because got_data stays 0.
REQ-030 An unreachable state encoding SHALL return to IDLE on the next edge.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE, word_cnt=0, all data_out bits 0, and got_data=start=buffer_full=0, regardless of clk.
REQ-032 Reset asserted mid-batch or mid-handshake SHALL discard partially captured words.
REQ-033 After reset deasserts, a new batch SHALL begin from slot 0.

Verification
REQ-034 Reset: assert rst between clock edges during ACK -> got_data and word_cnt are 0 without a clock edge; data_out=0.
REQ-035 Nominal batch: send 0x1111, 0x2222, 0x3333, 0x4444 with full handshakes; ready_for_input=1 -> data_out=0x4444_3333_2222_1111; start high for exactly 1 cycle; then IDLE.
REQ-036 Long request: hold data_ready=1 for 10 cycles with data_in=0xAAAA -> got_data stays high, word_cnt stays at its value, and exactly one slot is written.
REQ-037 Back-pressure: ready_for_input=0 after the 4th word -> buffer_full=1 and got_data=0 for 20 cycles; a new data_ready is not acknowledged. Raising ready_for_input -> start is pulsed on the next cycle.
REQ-038 Early core ready: ready_for_input=1 throughout the batch -> no start until the 4th handshake completes; start rises 1 cycle after WAIT_CORE is entered.
REQ-039 Back-to-back batches: run two batches with words 0x0001..0x0004, then 0x0005..0x0008 -> second data_out=0x0008_0007_0006_0005; word_cnt wraps 3->0.
